// File: rtl/shift_right_seq_8bit.sv
// Iterative right shifter: captures an operand on start, shifts one bit per
// clock (logical, arithmetic or rotate), then presents a registered result,
// the last bit shifted out and a one-cycle done pulse.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while idle
//   A      - operand, captured on an accepted start
//   Shamt  - shift amount 0..WIDTH-1, captured on an accepted start
//   Mode   - 00 logical, 01 arithmetic, 10 rotate right, 11 logical
//   busy   - high while shifting and during the done cycle
//   done   - one-cycle completion pulse
//   Y      - registered result, held until the next completion
//   Cout   - last bit shifted out of bit 0 (0 for a zero shift)
module shift_right_seq_8bit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [1:0]         Mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Y,
  output logic               Cout
);

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     work;
  logic [SHAMT_W-1:0]   cnt;
  logic [1:0]           mode_q;

  logic                 msb_in;
  logic [WIDTH-1:0]     shifted;

  // Fill bit entering at the MSB; mode 11 falls through to logical.
  always_comb begin
    msb_in = 1'b0;
    case (mode_q)
      MODE_ARITH:  msb_in = work[WIDTH-1];
      MODE_ROTATE: msb_in = work[0];
      default:     msb_in = 1'b0;
    endcase
    shifted = {msb_in, work[WIDTH-1:1]};
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      mode_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Y      <= '0;
      Cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work   <= A;
            cnt    <= Shamt;
            mode_q <= Mode;
            busy   <= 1'b1;
            if (Shamt == SHAMT_W'(0)) begin
              // Zero shift completes immediately with the operand unchanged.
              Y     <= A;
              Cout  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            Y     <= shifted;
            Cout  <= work[0];
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
